// File: rtl/stim_seq.sv
// Programmable three-bit stimulus sequencer: plays stored {A,B,C} vectors, each
// for a programmed number of cycles, from registered outputs, optionally looping.
module stim_seq #(
    parameter int DEPTH  = 8,
    parameter int HOLD_W = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_en,
    input  logic [AW-1:0]     load_addr,
    input  logic [2:0]        load_vec,
    input  logic [HOLD_W-1:0] load_hold,
    input  logic [AW:0]       seq_len,
    input  logic              loop,
    input  logic              start,
    input  logic              stop,
    output logic              a,
    output logic              b,
    output logic              c,
    output logic              busy,
    output logic              done,
    output logic [AW-1:0]     step
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

    logic [2:0]        r_memVec  [DEPTH];
    logic [HOLD_W-1:0] r_memHold [DEPTH];

    state_t            r_state;
    logic [2:0]        r_vec;
    logic [AW-1:0]     r_step;
    logic [HOLD_W-1:0] r_cnt;
    logic [AW:0]       r_len;
    logic              r_loop;
    logic              r_done;

    state_t            w_stateNext;
    logic [2:0]        w_vecNext;
    logic [AW-1:0]     w_stepNext;
    logic [HOLD_W-1:0] w_cntNext;
    logic [AW:0]       w_lenNext;
    logic              w_loopNext;
    logic              w_doneNext;
    logic [AW-1:0]     w_stepInc;
    logic [AW:0]       w_lenLast;
    logic [AW:0]       w_lenClamp;

    assign w_stepInc  = r_step + AW'(1);
    assign w_lenLast  = r_len - (AW+1)'(1);
    assign w_lenClamp = (seq_len > LP_DEPTH) ? LP_DEPTH : seq_len;

    // Pattern memory has no reset so stored patterns survive a reset mid-run.
    always_ff @(posedge clock) begin
        if (load_en && (r_state == IDLE)) begin
            r_memVec[load_addr]  <= load_vec;
            r_memHold[load_addr] <= load_hold;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_vec   <= '0;
            r_step  <= '0;
            r_cnt   <= '0;
            r_len   <= '0;
            r_loop  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_vec   <= w_vecNext;
            r_step  <= w_stepNext;
            r_cnt   <= w_cntNext;
            r_len   <= w_lenNext;
            r_loop  <= w_loopNext;
            r_done  <= w_doneNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_vecNext   = r_vec;
        w_stepNext  = r_step;
        w_cntNext   = r_cnt;
        w_lenNext   = r_len;
        w_loopNext  = r_loop;
        w_doneNext  = 1'b0;

        if (stop) begin
            w_stateNext = IDLE;
            w_vecNext   = 3'b000;
            w_stepNext  = '0;
            w_cntNext   = '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        if (seq_len == '0) begin
                            w_doneNext = 1'b1;
                        end else begin
                            w_lenNext   = w_lenClamp;
                            w_loopNext  = loop;
                            w_stepNext  = '0;
                            w_vecNext   = r_memVec[0];
                            w_cntNext   = r_memHold[0];
                            w_stateNext = RUN;
                        end
                    end
                end
                RUN: begin
                    if (r_cnt != '0) begin
                        w_cntNext = r_cnt - HOLD_W'(1);
                    end else if ({1'b0, r_step} != w_lenLast) begin
                        w_stepNext = w_stepInc;
                        w_vecNext  = r_memVec[w_stepInc];
                        w_cntNext  = r_memHold[w_stepInc];
                    end else if (r_loop) begin
                        w_stepNext = '0;
                        w_vecNext  = r_memVec[0];
                        w_cntNext  = r_memHold[0];
                    end else begin
                        // Done is raised in the same cycle the outputs return to 000.
                        w_stepNext  = '0;
                        w_vecNext   = 3'b000;
                        w_doneNext  = 1'b1;
                        w_stateNext = IDLE;
                    end
                end
                default: w_stateNext = IDLE;
            endcase
        end
    end

    assign {a, b, c} = r_vec;
    assign busy      = (r_state == RUN);
    assign done      = r_done;
    assign step      = r_step;

endmodule
